// File: rtl/montgomery_enter_serial.sv
// Bit-serial entry into Montgomery form: result_o = x_i * 2^k mod m_i, one doubling step per clock.
// Optional input precheck (m_i==0 or x_i>=m_i flagged on err_o) is built when MONT_ENTER_PRECHECK_EN is defined.
`timescale 1ns/1ps

package multiplier_pkg;
  parameter int DATA_LENGTH = 32;
endpackage

module montgomery_enter_serial
  import multiplier_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic                   busy_o,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   err_o
);

  localparam int CW = $clog2(DATA_LENGTH + 1);
  localparam logic [DATA_LENGTH-1:0] K_MAX = DATA_LENGTH'(DATA_LENGTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]             state;
  logic [DATA_LENGTH:0]   r;
  logic [DATA_LENGTH-1:0] m_q;
  logic [CW-1:0]          cnt;

  logic [CW-1:0]          k_load;
  logic [DATA_LENGTH:0]   t;
  logic [DATA_LENGTH:0]   t_sub;
  logic                   t_ge;

  // Bit lengths beyond the datapath width saturate to the full width.
  assign k_load = (m_bl_i > K_MAX) ? CW'(DATA_LENGTH) : m_bl_i[CW-1:0];

  // r < m_q always holds, so 2r fits in DATA_LENGTH+1 bits and one subtract suffices.
  assign t     = r << 1;
  assign t_ge  = (t >= {1'b0, m_q});
  assign t_sub = t - {1'b0, m_q};

  // The valid cycle is already IDLE, so a held start_i is accepted there (back-to-back).
  assign busy_o = (state != IDLE) || valid_o;

`ifdef MONT_ENTER_PRECHECK_EN
  logic bad_in;
  logic err_pend;

  assign bad_in = (m_i == '0) || (x_i >= m_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pend <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (state == IDLE && start_i) begin
        err_pend <= bad_in;
      end
      if (state == DONE) begin
        err_o <= err_pend;
      end
    end
  end
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      r        <= '0;
      m_q      <= '0;
      cnt      <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            r   <= {1'b0, x_i};
            m_q <= m_i;
            cnt <= k_load;
`ifdef MONT_ENTER_PRECHECK_EN
            if (bad_in) begin
              state <= DONE;
            end else begin
              state <= (k_load != '0) ? SHIFT : DONE;
            end
`else
            state <= (k_load != '0) ? SHIFT : DONE;
`endif
          end
        end
        SHIFT: begin
          r   <= t_ge ? t_sub : t;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
`ifdef MONT_ENTER_PRECHECK_EN
          result_o <= err_pend ? '0 : r[DATA_LENGTH-1:0];
`else
          result_o <= r[DATA_LENGTH-1:0];
`endif
          valid_o  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_enter_serial.sv
// Directed self-checking bench for montgomery_enter_serial (x * 2^k mod m, bit-serial).
`timescale 1ns/1ps

module tb_montgomery_enter_serial;
  import multiplier_pkg::*;
  localparam int DL = DATA_LENGTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DL-1:0] x = '0;
  logic [DL-1:0] m = '0;
  logic [DL-1:0] mbl = '0;
  logic          busy;
  logic [DL-1:0] result;
  logic          valid;
  logic          err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  montgomery_enter_serial dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .x_i      (x),
    .m_i      (m),
    .m_bl_i   (mbl),
    .busy_o   (busy),
    .result_o (result),
    .valid_o  (valid),
    .err_o    (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input string tag, input logic [DL-1:0] xv, input logic [DL-1:0] mv,
                         input logic [DL-1:0] kv, input logic [DL-1:0] exp_res,
                         input logic exp_err, input int exp_lat);
    int lat;
    bit seen;
    x = xv; m = mv; mbl = kv; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    seen = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    for (int i = 0; i < 200 && !seen; i++) begin
      tick;
      lat++;
      if (valid) seen = 1'b1;
    end
    chk({tag, "_valid_seen"}, seen, 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_valid"}, busy, 1);
    $display("conv %s x=%0d m=%0d k=%0d result=%0d err=%0d latency=%0d", tag, xv, mv, kv, result, err, lat);
    tick;
    chk({tag, "_pulse"}, valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int pulses;
    int pos [3];
    int vcount;

    // Reset state
    rst = 1'b1;
    tick;
    tick;
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick;

    convert("m13_x5", 5, 13, 4, 2, 0, 6);
    convert("kyber_x1", 1, 3329, 12, 767, 0, 14);
    convert("kyber_x3328", 3328, 3329, 12, 2562, 0, 14);
    convert("k0_x9", 9, 13, 0, 9, 0, 2);
    convert("x0", 0, 3329, 12, 0, 0, 14);
    convert("k_sat", 1, 13, 40, 9, 0, 34);
    convert("wide", 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32, 32'hFFFF_FFF6, 0, 34);

    // start held high: one conversion per IDLE visit; x changed mid-SHIFT only affects later requests
    pulses = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    x = 5; m = 13; mbl = 4; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 3) x = 7;
      if (valid) begin
        if (pulses < 3) pos[pulses] = c;
        chk($sformatf("held_result_%0d", pulses), result, (pulses == 0) ? 2 : 8);
        chk($sformatf("held_err_%0d", pulses), err, 0);
        pulses++;
        $display("held pulse cycle=%0d result=%0d", c, result);
      end
    end
    start = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_pos0", pos[0], 6);
    chk("held_pos1", pos[1], 12);
    chk("held_pos2", pos[2], 18);
    for (int i = 0; i < 20 && busy; i++) tick;
    chk("held_drained", busy, 0);
    chk("held_last_result", result, 8);

    // Reset in the middle of a k=12 conversion
    x = 1; m = 3329; mbl = 12; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_result", result, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (valid || busy) vcount++;
    end
    chk("midrst_no_valid", vcount, 0);
    $display("reset mid-conversion dropped, activity=%0d", vcount);
    convert("after_rst", 3328, 3329, 12, 2562, 0, 14);

    // Reset and start at the same edge: reset wins
    x = 5; m = 13; mbl = 4; start = 1'b1; rst = 1'b1;
    tick;
    start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", busy, 0);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (valid) vcount++;
    end
    chk("rst_start_no_valid", vcount, 0);
    $display("reset with start: request lost, valids=%0d", vcount);

`ifdef MONT_ENTER_PRECHECK_EN
    convert("pre_x_eq_m", 13, 13, 4, 0, 1, 2);
    convert("pre_m0", 5, 0, 4, 0, 1, 2);
    convert("pre_ok", 5, 13, 4, 2, 0, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
